// File: rtl/lisa_qqspi_if.sv
// Request/response bus between a host and the quad-SPI controller.
// The host drives a request, then steps through words with ready/ready_ack.
interface lisa_qqspi_if #(parameter int CHIP_SELECTS = 2);
  logic [23:0]             addr;
  logic [15:0]             wdata;
  logic [1:0]              wstrb;
  logic                    valid;
  logic [3:0]              xfer_len;
  logic [CHIP_SELECTS-1:0] ce_ctrl;
  logic                    custom_spi_cmd;
  logic [7:0]              cmd_quad_write;
  logic                    ready_ack;
  logic [15:0]             rdata;
  logic                    ready;
  logic                    xfer_done;

  modport master (output addr, wdata, wstrb, valid, xfer_len, ce_ctrl, custom_spi_cmd,
                  cmd_quad_write, ready_ack, input rdata, ready, xfer_done);
  modport slave  (input addr, wdata, wstrb, valid, xfer_len, ce_ctrl, custom_spi_cmd,
                  cmd_quad_write, ready_ack, output rdata, ready, xfer_done);
endinterface

// File: rtl/lisa_qqspi.sv
// Quad-SPI memory controller: command, address, dummy and 16-bit word data phases
// with a per-word ready/ack handshake; SCLK runs at clk/2.
module lisa_qqspi #(
  parameter int          CHIP_SELECTS = 2,
  parameter logic [7:0]  CMD_READ     = 8'hEB,
  parameter logic [7:0]  CMD_WRITE    = 8'h38,
  parameter int          READ_DUMMY   = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lisa_qqspi_if.slave             bus,
  output logic                    sclk,
  output logic [CHIP_SELECTS-1:0] ce_n,
  output logic [3:0]              sio_out,
  output logic [3:0]              sio_oe,
  input  logic [3:0]              sio_in
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, WAIT_ACK, CE_HOLD, GAP} state_t;

  localparam logic [3:0] DUMMY_LAST = 4'(READ_DUMMY - 1);

  state_t      state_q, state_d;
  logic        ph_q, ph_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  word_q, len_q;
  logic        wr_q, custom_q;
  logic [7:0]  cmd_q, cmd_in, cur_cmd;
  logic [23:0] addr_q;
  logic [5:0][3:0] addr_nib;
  logic [15:0] wdata_q, cur_wdata;
  logic [11:0] rx_q;
  logic [15:0] rdata_q;
  logic        ready_q, done_q;
  logic [3:0]  out_d, oe_d;
  logic        load_lo;

  function automatic logic sclk_st(input state_t s);
    return s inside {CMD, ADDR, DUMMY, DATA};
  endfunction

  assign addr_nib      = addr_q;
  assign cmd_in        = bus.custom_spi_cmd ? bus.cmd_quad_write :
                         (|bus.wstrb ? CMD_WRITE : CMD_READ);
  assign cur_cmd       = (state_q == IDLE) ? cmd_in : cmd_q;
  // Next word's first nibble leaves on the ack edge, before wdata_q has it.
  assign cur_wdata     = (state_q == WAIT_ACK) ? bus.wdata : wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.ready     = ready_q;
  assign bus.xfer_done = done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.valid) state_d = CMD;
      CMD:      if (ph_q && cnt_q == 4'd7) state_d = custom_q ? CE_HOLD : ADDR;
      ADDR:     if (ph_q && cnt_q == 4'd5) state_d = wr_q ? DATA : DUMMY;
      DUMMY:    if (ph_q && cnt_q == DUMMY_LAST) state_d = DATA;
      DATA:     if (ph_q && cnt_q == 4'd3) state_d = WAIT_ACK;
      WAIT_ACK: if (bus.ready_ack) state_d = (word_q == len_q) ? CE_HOLD : DATA;
      CE_HOLD:  state_d = GAP;
      GAP:      if (cnt_q == 4'd1) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    ph_d  = sclk_st(state_q) && sclk_st(state_d) && !ph_q;
    cnt_d = cnt_q;
    if (state_d != state_q)            cnt_d = '0;
    else if (ph_q || state_q == GAP)   cnt_d = cnt_q + 4'd1;
    // Inside the SCLK states every cycle with ph_d=0 starts a low phase.
    load_lo = sclk_st(state_d) && !ph_d;

    out_d = 4'h0;
    oe_d  = 4'h0;
    case (state_d)
      CMD:  begin oe_d = 4'b0001; out_d = {3'b000, cur_cmd[3'd7 - cnt_d[2:0]]}; end
      ADDR: begin oe_d = 4'hF;    out_d = addr_nib[3'd5 - cnt_d[2:0]]; end
      DATA: if (wr_q) begin
        oe_d = 4'hF;
        case (cnt_d[1:0])
          2'd0:    out_d = cur_wdata[7:4];
          2'd1:    out_d = cur_wdata[3:0];
          2'd2:    out_d = cur_wdata[15:12];
          default: out_d = cur_wdata[11:8];
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;  ph_q <= 1'b0;  cnt_q <= '0;  word_q <= '0;  len_q <= '0;
      wr_q <= 1'b0;  custom_q <= 1'b0;  cmd_q <= '0;  addr_q <= '0;  wdata_q <= '0;
      rx_q <= '0;  rdata_q <= '0;  ready_q <= 1'b0;  done_q <= 1'b0;
      sclk <= 1'b0;  ce_n <= '1;  sio_out <= '0;  sio_oe <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      sclk    <= ph_d;
      ready_q <= (state_d == WAIT_ACK);
      done_q  <= (state_d == CE_HOLD);

      if (state_q == IDLE && bus.valid) begin
        addr_q   <= bus.addr;
        len_q    <= {bus.xfer_len == 4'd0, bus.xfer_len};
        wr_q     <= |bus.wstrb;
        custom_q <= bus.custom_spi_cmd;
        cmd_q    <= cmd_in;
        wdata_q  <= bus.wdata;
        word_q   <= '0;
        ce_n     <= ~bus.ce_ctrl;
      end
      if (state_q == WAIT_ACK && bus.ready_ack) wdata_q <= bus.wdata;
      if (state_q == DATA && state_d == WAIT_ACK) word_q <= word_q + 5'd1;
      if (state_d == CE_HOLD) ce_n <= '1;

      if (load_lo) begin
        sio_out <= out_d;
        sio_oe  <= oe_d;
      end else if (!sclk_st(state_d) && state_d != WAIT_ACK) begin
        sio_out <= '0;
        sio_oe  <= '0;
      end

      // Final nibble lands straight in rdata so it is valid on the ready edge.
      if (state_q == DATA && ph_q && !wr_q) begin
        rx_q <= {rx_q[7:0], sio_in};
        if (cnt_q == 4'd3) rdata_q <= {rx_q[3:0], sio_in, rx_q[11:8], rx_q[7:4]};
      end
    end
  end
endmodule

// File: doc/lisa_qqspi.md
LISA_QQSPI -- requirements
Module: lisa_qqspi

Interface
REQ-001 Parameter CHIP_SELECTS, default 2: number of chip-select pins.
REQ-002 Parameter CMD_READ, default 8'hEB: quad-I/O read command byte.
REQ-003 Parameter CMD_WRITE, default 8'h38: quad write command byte.
REQ-004 Parameter READ_DUMMY, default 6: number of dummy SCLK cycles on a read (range 1..15).
REQ-005 Reset rst_n is synchronous and active-low; the clock is clk.
REQ-006 Request and response ports shall be as follows:
- clk  in  1  system clock
- rst_n  in  1  sync active-low reset
- addr  in  24  byte start address
- wdata  in  16  write word
- wstrb  in  2  nonzero = write, zero = read; byte-granular writes are not supported
- valid  in  1  request start
- xfer_len  in  4  16-bit words; 0 = 16
- ce_ctrl  in  CHIP_SELECTS  bit=1 asserts that ce_n
- custom_spi_cmd  in  1  command-only transaction
- cmd_quad_write  in  8  custom command byte
- ready_ack  in  1  word acknowledge
- rdata  out  16  read word
- ready  out  1  word complete
- xfer_done  out  1  transaction complete pulse
- sclk  out  1  SPI clock
- ce_n  out  CHIP_SELECTS  chip selects, active low
- sio_out  out  4  SPI data out
- sio_oe  out  4  per-lane output enable
- sio_in  in  4  SPI data in

Function
REQ-007 SCLK shall run at clk/2: each SCLK period is two clk cycles, low phase then high phase.
REQ-008 sio_out shall change only on entry to the low phase; sio_in shall be captured on the clk edge that ends the high phase.
REQ-009 The FSM shall have the states IDLE, CMD, ADDR, DUMMY, DATA, WAIT_ACK, CE_HOLD and GAP.
REQ-010 valid shall be sampled only in IDLE; on valid=1, addr, xfer_len, ce_ctrl, the direction, custom_spi_cmd and wdata shall be latched, and ce_n shall go low on the next cycle.
REQ-011 valid asserted outside IDLE shall be ignored.
REQ-012 CMD: 8 SCLK, sio_oe=4'b0001, byte MSB-first on sio_out[0].
- Command byte = cmd_quad_write if custom_spi_cmd=1; else CMD_WRITE for writes; else CMD_READ.
REQ-013 When custom_spi_cmd=1, CMD shall be followed directly by CE_HOLD, and addr and data shall be ignored.
REQ-014 ADDR: 6 SCLK, sio_oe=4'b1111, addr[23:0] shifted one nibble per SCLK, MSB nibble first.
REQ-015 Reads shall then enter DUMMY for READ_DUMMY SCLK with sio_oe=0; writes shall skip DUMMY.
REQ-016 DATA: 4 SCLK per word, nibble order [7:4],[3:0],[15:12],[11:8] (low byte at the lower address).
- sio_oe=4'b1111 for writes, 0 for reads.
REQ-017 After each word, ready shall assert and the FSM shall enter WAIT_ACK.
- sclk held low, ce_n held low, until ready_ack=1 is sampled.
- ready deasserts the cycle after the ack.
REQ-018 Read: rdata shall be updated on the same cycle ready rises and held stable until the next word's ready.
REQ-019 Write: ready means the current word has been consumed.
- The requester presents the next wdata no later than the ack cycle.
- The controller captures it on the ack cycle.
REQ-020 ready_ack=1 while ready=0 shall be ignored.
REQ-021 After the ack of word xfer_len (16 if xfer_len=0), the FSM shall enter CE_HOLD.
REQ-022 CE_HOLD: ce_n shall go all-ones, sio_oe=0, and xfer_done shall pulse high for exactly one cycle.
REQ-023 GAP: 2 clk with ce_n high before returning to IDLE, with valid ignored.
REQ-024 Single-word latency, CE low to ready: read 16+12+2*READ_DUMMY+8 clk (48 at default); write 36 clk.
REQ-025 The internal word counter shall be 5 bits so that 16 words do not wrap.
REQ-026 The address shall be sent only once; the memory auto-increments.

Reset
REQ-027 With rst_n=0 at a clk edge, the following shall hold next cycle regardless of state:
- ce_n all ones, sclk=0
- sio_out=0, sio_oe=0
- ready=0, xfer_done=0, rdata=0
- FSM in IDLE
REQ-028 A reset mid-transaction shall produce no xfer_done pulse.

Verification
REQ-029 Read: addr=24'h000100, wstrb=0, xfer_len=1, ce_ctrl=2'b01, model returns 16'hBEEF.
- Expect ce_n=2'b10, cmd EB on sio0, addr nibbles 0,0,0,1,0,0.
- ready at clk 48 with rdata=16'hBEEF.
- Ack -> one-cycle xfer_done.
REQ-030 Write: wstrb=2'b11, xfer_len=2, wdata 16'h1234 then 16'h5678, ready_ack delayed 5 cycles.
- Expect cmd 38; nibbles 3,4,1,2,7,8,5,6.
- sclk frozen low during each wait.
REQ-031 Custom: custom_spi_cmd=1, cmd_quad_write=8'h35.
- Expect exactly 8 SCLK, sio_oe=4'b0001, no ready, then xfer_done.
REQ-032 xfer_len=0 read: expect exactly 16 ready/ack pairs and 64 data SCLK, then xfer_done.
REQ-033 Reset during the DATA phase of a read: expect ce_n all ones next cycle and no xfer_done.
- A valid asserted during GAP is not accepted, and is accepted once the FSM is in IDLE.
